// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI slave engine and its pin synchronizers.
package spi_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_slv_state_t;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

    localparam int SPI_SYNC_STAGES_DEFAULT = 2;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin, plus one previous-value flop that
// yields single-cycle rise/fall strobes on the synchronized level.
module spi_sync_edge
    import spi_pkg::*;
#(
    parameter int   STAGES  = SPI_SYNC_STAGES_DEFAULT,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples
    // the pre-edge value of its neighbour and the chain shifts by exactly one stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= {STAGES{RST_VAL}};
            r_prev <= RST_VAL;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign o_level = r_sync[STAGES-1];
    assign o_rise  = o_level & ~r_prev;
    assign o_fall  = ~o_level & r_prev;

endmodule

// File: rtl/spi_slave_core.sv
// SPI slave engine: synchronizes the remote master's pins into clk, deserializes MOSI
// into words and serializes MISO from a one-entry TX holding buffer.
module spi_slave_core
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = SPI_SYNC_STAGES_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cpol,
    input  logic                  cpha,
    input  logic                  sclk_in,
    input  logic                  cs_n_in,
    input  logic                  mosi_in,
    output logic                  miso_out,
    output logic                  miso_oe,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  frame_active,
    output logic                  underrun,
    output logic                  frame_abort
);

    localparam int               CNT_W    = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    spi_slv_state_t         r_state, w_state_next;
    spi_mode_t              r_mode;
    logic [CNT_W-1:0]       r_bit_cnt;
    logic [DATA_WIDTH-2:0]  r_rx_shift;
    logic [DATA_WIDTH-1:0]  r_rx_data, r_tx_shift, r_buf;
    logic                   r_buf_full, r_skip_shift;
    logic                   r_rx_valid, r_underrun, r_frame_abort;
    logic [SYNC_STAGES-1:0] r_mosi_sync;

    logic w_sclk_s, w_sclk_rise, w_sclk_fall, w_sclk_edge;
    logic w_cs_n_s, w_cs_rise, w_cs_fall, w_mosi_s;
    logic w_lead, w_trail, w_edges_en, w_sample, w_shift;
    logic w_word_done, w_load, w_accept, w_frame_start, w_frame_end;
    logic [DATA_WIDTH-1:0] w_rx_word;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_d     (sclk_in),
        .o_level (w_sclk_s),
        .o_rise  (w_sclk_rise),
        .o_fall  (w_sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_d     (cs_n_in),
        .o_level (w_cs_n_s),
        .o_rise  (w_cs_rise),
        .o_fall  (w_cs_fall)
    );

    // Same depth as the SCLK chain so each sample edge sees the MOSI bit that was
    // on the pin when the master produced that edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_mosi_sync <= '0;
        else        r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi_in};
    end
    assign w_mosi_s = r_mosi_sync[SYNC_STAGES-1];

    // A leading edge leaves the latched idle level, a trailing edge returns to it.
    assign w_sclk_edge = w_sclk_rise | w_sclk_fall;
    assign w_lead      = w_sclk_edge & (w_sclk_s ^ r_mode.cpol);
    assign w_trail     = w_sclk_edge & ~(w_sclk_s ^ r_mode.cpol);
    assign w_edges_en  = (r_state == ACTIVE) & ~w_cs_rise;
    assign w_sample    = w_edges_en & (r_mode.cpha ? w_trail : w_lead);
    assign w_shift     = w_edges_en & (r_mode.cpha ? w_lead : w_trail);
    assign w_word_done = w_sample & (r_bit_cnt == LAST_BIT);
    assign w_load      = w_frame_start | w_word_done;
    assign w_accept    = tx_valid & ~r_buf_full;
    assign w_rx_word   = {r_rx_shift, w_mosi_s};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    // NOTE: every output of this block gets a default before the case, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_state_next  = r_state;
        w_frame_start = 1'b0;
        w_frame_end   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_cs_fall) begin
                    w_state_next  = ACTIVE;
                    w_frame_start = 1'b1;
                end
            end
            ACTIVE: begin
                if (w_cs_rise) begin
                    w_state_next = IDLE;
                    w_frame_end  = 1'b1;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // NOTE: the holding buffer and shift registers are plain flops, not a memory
    // array, so they are reset with everything else and never expose stale data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode        <= '0;
            r_bit_cnt     <= '0;
            r_rx_shift    <= '0;
            r_rx_data     <= '0;
            r_tx_shift    <= '0;
            r_buf         <= '0;
            r_buf_full    <= 1'b0;
            r_skip_shift  <= 1'b0;
            r_rx_valid    <= 1'b0;
            r_underrun    <= 1'b0;
            r_frame_abort <= 1'b0;
        end else begin
            r_rx_valid    <= 1'b0;
            r_underrun    <= 1'b0;
            r_frame_abort <= 1'b0;

            if (w_frame_start) begin
                r_mode.cpol  <= cpol;
                r_mode.cpha  <= cpha;
                r_bit_cnt    <= '0;
                r_skip_shift <= cpha;
            end

            if (w_frame_end) r_frame_abort <= (r_bit_cnt != '0);

            if (w_sample) begin
                r_rx_shift <= w_rx_word[DATA_WIDTH-2:0];
                if (w_word_done) begin
                    r_rx_data    <= w_rx_word;
                    r_rx_valid   <= 1'b1;
                    r_bit_cnt    <= '0;
                    r_skip_shift <= 1'b1;
                end else begin
                    r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                end
            end

            // The first shift edge after a fresh load would discard the MSB before the
            // master has sampled it.
            if (w_shift) begin
                if (r_skip_shift) r_skip_shift <= 1'b0;
                else              r_tx_shift   <= {r_tx_shift[DATA_WIDTH-2:0], 1'b0};
            end

            if (w_load) begin
                r_tx_shift <= r_buf_full ? r_buf : '0;
                r_underrun <= ~r_buf_full;
            end

            // The load above sees the pre-accept buffer; a same-cycle accept refills it.
            if (w_accept) begin
                r_buf      <= tx_data;
                r_buf_full <= 1'b1;
            end else if (w_load) begin
                r_buf_full <= 1'b0;
            end
        end
    end

    assign miso_out     = r_tx_shift[DATA_WIDTH-1];
    assign miso_oe      = ~w_cs_n_s;
    assign tx_ready     = ~r_buf_full;
    assign rx_data      = r_rx_data;
    assign rx_valid     = r_rx_valid;
    assign frame_active = (r_state == ACTIVE);
    assign underrun     = r_underrun;
    assign frame_abort  = r_frame_abort;

endmodule

// File: tb/tb_spi_slave_core.sv
// Self-checking bench for spi_slave_core: a behavioural SPI master drives the pins and
// scoreboards the received words and the captured MISO words.
module tb_spi_slave_core;

    localparam int W    = 8;
    localparam int HALF = 4;  // clk cycles per SCLK half period (SCLK = clk/8)

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cpol = 1'b0, cpha = 1'b0;
    logic         sclk_in = 1'b0, cs_n_in = 1'b1, mosi_in = 1'b0;
    logic [W-1:0] tx_data = '0;
    logic         tx_valid = 1'b0;
    logic         miso_out, miso_oe, tx_ready, rx_valid, frame_active, underrun, frame_abort;
    logic [W-1:0] rx_data;

    always #5 clk = ~clk;

    spi_slave_core #(.DATA_WIDTH(W), .SYNC_STAGES(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cpol         (cpol),
        .cpha         (cpha),
        .sclk_in      (sclk_in),
        .cs_n_in      (cs_n_in),
        .mosi_in      (mosi_in),
        .miso_out     (miso_out),
        .miso_oe      (miso_oe),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .frame_active (frame_active),
        .underrun     (underrun),
        .frame_abort  (frame_abort)
    );

    int           n_checks = 0, n_errors = 0;
    int           n_rxv = 0, n_ur = 0, n_ur_word = 0, n_abort = 0;
    int           b_rxv, b_ur, b_urw, b_abort, first_ur;
    logic [W-1:0] rx_q[$];    // words the master sent, awaiting rx_valid
    logic [W-1:0] miso_q[$];  // words the master should capture on MISO
    logic [W-1:0] m_mosi[4];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Output monitor: pops the receive scoreboard and tallies the strobes.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid) begin
                n_rxv++;
                if (rx_q.size() == 0) check("rx_unexpected", 32'(rx_valid), 32'd0);
                else                  check("rx_word", 32'(rx_data), 32'(rx_q.pop_front()));
            end
            if (underrun) begin
                n_ur++;
                if (rx_valid) n_ur_word++;
                if (first_ur < 0) first_ur = rx_valid ? (n_rxv - b_rxv) : 0;
            end
            if (frame_abort) n_abort++;
        end
    end

    task automatic snap();
        b_rxv = n_rxv; b_ur = n_ur; b_urw = n_ur_word; b_abort = n_abort; first_ur = -1;
    endtask

    task automatic check_counts(input string tag, input int rxv, input int ur, input int urw,
                                input int ab);
        check({tag, "_rx_count"},       32'(n_rxv - b_rxv),       32'(rxv));
        check({tag, "_underrun_count"}, 32'(n_ur - b_ur),         32'(ur));
        check({tag, "_underrun_word"},  32'(n_ur_word - b_urw),   32'(urw));
        check({tag, "_abort_count"},    32'(n_abort - b_abort),   32'(ab));
        check({tag, "_rx_drained"},     32'(rx_q.size()),         32'd0);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_miso_out"},     32'(miso_out),     32'd0);
        check({tag, "_miso_oe"},      32'(miso_oe),      32'd0);
        check({tag, "_tx_ready"},     32'(tx_ready),     32'd1);
        check({tag, "_rx_data"},      32'(rx_data),      32'd0);
        check({tag, "_rx_valid"},     32'(rx_valid),     32'd0);
        check({tag, "_frame_active"}, 32'(frame_active), 32'd0);
        check({tag, "_underrun"},     32'(underrun),     32'd0);
        check({tag, "_frame_abort"},  32'(frame_abort),  32'd0);
    endtask

    // Fill the TX holding buffer and record the word the master should see.
    task automatic load_tx(input logic [W-1:0] d);
        int cyc = 0;
        @(negedge clk);
        tx_data  = d;
        tx_valid = 1'b1;
        while (!tx_ready && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 200) check("load_tx_timeout", 32'(tx_ready), 32'd1);
        @(negedge clk);
        tx_valid = 1'b0;
        miso_q.push_back(d);
    endtask

    // Master: n_words from m_mosi, optionally stopping after stop_bits SCLK cycles.
    task automatic spi_frame(input logic m_cpol, input logic m_cpha, input int n_words,
                             input int stop_bits, input bit raise_cs, input string tag);
        int           limit;
        logic [W-1:0] cap = '0;
        limit = (stop_bits > 0) ? stop_bits : n_words * W;
        @(negedge clk);
        cpol    = m_cpol;
        cpha    = m_cpha;
        sclk_in = m_cpol;
        if (!m_cpha) mosi_in = m_mosi[0][W-1];
        repeat (6) @(negedge clk);
        cs_n_in = 1'b0;
        repeat (2 * HALF) @(negedge clk);
        check({tag, "_oe_in_frame"},     32'(miso_oe),      32'd1);
        check({tag, "_active_in_frame"}, 32'(frame_active), 32'd1);
        for (int k = 0; k < limit; k++) begin
            if (k % W == 0 && k + W <= limit) rx_q.push_back(m_mosi[k / W]);
            sclk_in = ~m_cpol;
            if (m_cpha) mosi_in = m_mosi[k / W][W - 1 - (k % W)];
            else        cap = {cap[W-2:0], miso_out};
            repeat (HALF) @(negedge clk);
            sclk_in = m_cpol;
            if (m_cpha)            cap = {cap[W-2:0], miso_out};
            else if (k + 1 < limit) mosi_in = m_mosi[(k + 1) / W][W - 1 - ((k + 1) % W)];
            repeat (HALF) @(negedge clk);
            if (k % W == W - 1) begin
                if (miso_q.size() == 0) check({tag, "_miso_plan"}, 32'(miso_q.size()), 32'd1);
                else                    check({tag, "_miso_word"}, 32'(cap), 32'(miso_q.pop_front()));
            end
        end
        repeat (2 * HALF) @(negedge clk);
        if (raise_cs) begin
            cs_n_in = 1'b1;
            repeat (2 * HALF) @(negedge clk);
            check({tag, "_active_after"}, 32'(frame_active), 32'd0);
            check({tag, "_oe_after"},     32'(miso_oe),      32'd0);
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        first_ur = -1;
        repeat (3) @(negedge clk);
        check_reset("por");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Mode 0, one word; the end-of-word reload finds the buffer empty.
        snap();
        load_tx(8'h3C);
        m_mosi[0] = 8'hA5;
        spi_frame(1'b0, 1'b0, 1, 0, 1'b1, "t1");
        check_counts("t1", 1, 1, 1, 0);
        check("t1_no_start_underrun", 32'(first_ur), 32'd1);
        check("t1_rx_data_held", 32'(rx_data), 32'hA5);

        // Mode 3: SCLK idles high before CS_N falls and must not add bits.
        snap();
        load_tx(8'h81);
        m_mosi[0] = 8'h5A;
        spi_frame(1'b1, 1'b1, 1, 0, 1'b1, "t2");
        check_counts("t2", 1, 1, 1, 0);

        // Two words, one TX word: the first completion reload already underruns.
        snap();
        load_tx(8'hE7);
        miso_q.push_back(8'h00);
        m_mosi[0] = 8'hC9;
        m_mosi[1] = 8'h36;
        spi_frame(1'b0, 1'b0, 2, 0, 1'b1, "t3");
        check_counts("t3", 2, 2, 2, 0);
        check("t3_first_underrun_at_word1", 32'(first_ur), 32'd1);

        // Abort after 5 SCLK cycles, then a clean frame.
        snap();
        load_tx(8'h77);
        m_mosi[0] = 8'hF0;
        spi_frame(1'b0, 1'b0, 1, 5, 1'b1, "t4a");
        miso_q.delete();
        check_counts("t4a", 0, 0, 0, 1);
        snap();
        load_tx(8'h44);
        m_mosi[0] = 8'h33;
        spi_frame(1'b0, 1'b0, 1, 0, 1'b1, "t4b");
        check_counts("t4b", 1, 1, 1, 0);

        // tx_valid raised exactly on the frame-start load, then held while full.
        snap();
        miso_q.push_back(8'h00);
        miso_q.push_back(8'h11);
        miso_q.push_back(8'h22);
        m_mosi[0] = 8'h6B;
        m_mosi[1] = 8'hD4;
        m_mosi[2] = 8'h2F;
        fork
            spi_frame(1'b0, 1'b0, 3, 0, 1'b1, "t5");
            begin : t5_drv
                int cyc;
                cyc = 0;
                @(negedge cs_n_in);
                repeat (2) @(negedge clk);
                tx_data  = 8'h11;
                tx_valid = 1'b1;
                @(negedge clk);
                check("t5_underrun_at_start", 32'(underrun), 32'd1);
                check("t5_coincident_accept", 32'(tx_ready), 32'd0);
                tx_data = 8'h22;
                while (!tx_ready && cyc < 400) begin
                    @(negedge clk);
                    cyc++;
                end
                check("t5_ready_rises_at_reload", 32'(rx_valid), 32'd1);
                @(negedge clk);
                tx_valid = 1'b0;
                check("t5_held_word_accepted", 32'(tx_ready), 32'd0);
            end
        join
        check_counts("t5", 3, 2, 1, 0);
        check("t5_first_underrun_at_start", 32'(first_ur), 32'd0);

        // Reset in the middle of a word, then a clean frame.
        snap();
        load_tx(8'h5E);
        m_mosi[0] = 8'hB1;
        spi_frame(1'b0, 1'b0, 1, 3, 1'b0, "t6a");
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset("t6_mid_reset");
        cs_n_in = 1'b1;
        sclk_in = 1'b0;
        mosi_in = 1'b0;
        miso_q.delete();
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("t6_frame_after_reset", 32'(frame_active), 32'd0);
        snap();
        load_tx(8'h96);
        m_mosi[0] = 8'hC3;
        spi_frame(1'b0, 1'b1, 1, 0, 1'b1, "t6b");
        check_counts("t6b", 1, 1, 1, 0);
        check("t6b_rx_data", 32'(rx_data), 32'hC3);
        check("end_miso_drained", 32'(miso_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
